gpr_writeback: RTL and testbench

//   Writeback stage feeding the GPR write port (RegWr/Rw/busW). Takes one retiring

---
 rtl/gpr_writeback_pkg.sv | 55 +++++
 rtl/gpr_writeback_if.sv | 40 ++++
 rtl/gpr_writeback_load_extend.sv | 33 +++
 rtl/gpr_writeback.sv | 108 ++++++++++
 tb/tb_gpr_writeback.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_writeback_pkg.sv
// Shared types for the GPR writeback stage: load funct3 codes, FSM states,
// and the registered commit bundle presented to the GPR write port.
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WB
    } wb_state_e;

    typedef struct packed {
        logic        regwr;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic        done;
        logic        exc;
    } wb_out_t;

    // Unknown widths and misaligned halfword/word addresses both raise an exception.
    function automatic logic load_illegal(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = off[0];
            F3_LW:         bad = (off != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

    // x0 is never written, and index/data stay zero whenever no write happens.
    function automatic wb_out_t wb_commit(input logic        err,
                                          input logic        wen,
                                          input logic [4:0]  rd,
                                          input logic [31:0] data);
        wb_out_t o;
        o      = '0;
        o.done = !err;
        o.exc  = err;
        if (!err && wen && (rd != 5'd0)) begin
            o.regwr = 1'b1;
            o.rw    = rd;
            o.busw  = data;
        end
        return o;
    endfunction

endpackage

// File: rtl/gpr_writeback_if.sv
// Bundle of the EXU handshake, data-memory read port and GPR write port
// seen by the writeback stage (slave) and its environment (master).
interface gpr_writeback_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [4:0]  in_rd;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_alu;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic        done;
    logic        exc;

    modport slave (
        input  in_valid, in_wen, in_rd, in_is_load, in_funct3, in_addr, in_alu,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output in_ready, mem_req_valid, mem_req_addr,
        output RegWr, Rw, busW, done, exc
    );

    modport master (
        output in_valid, in_wen, in_rd, in_is_load, in_funct3, in_addr, in_alu,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  in_ready, mem_req_valid, mem_req_addr,
        input  RegWr, Rw, busW, done, exc
    );

endinterface

// File: rtl/gpr_writeback_load_extend.sv
// Combinational load data aligner: picks the byte/half lane from the read word
// and sign- or zero-extends it according to funct3.
module load_extend
    import wb_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] word_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        case (off_i)
            2'd0:    byte_s = data_i[7:0];
            2'd1:    byte_s = data_i[15:8];
            2'd2:    byte_s = data_i[23:16];
            default: byte_s = data_i[31:24];
        endcase
        half_s = off_i[1] ? data_i[31:16] : data_i[15:0];

        case (funct3_i)
            F3_LB:   word_o = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  word_o = {24'd0, byte_s};
            F3_LH:   word_o = {{16{half_s[15]}}, half_s};
            F3_LHU:  word_o = {16'd0, half_s};
            default: word_o = data_i;
        endcase
    end

endmodule

// File: rtl/gpr_writeback.sv
// Writeback stage: accepts one retiring instruction, performs the load read if
// needed, and drives a one-cycle commit or exception onto the GPR write port.
module gpr_writeback
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            WrClk,
    input  logic            rst,
    gpr_writeback_if.slave  bus
);

    localparam logic [7:0] TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    wb_state_e   state_q;
    logic [7:0]  cnt_q;
    logic        wen_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic        ready_q;
    logic        req_valid_q;
    wb_out_t     out_q;
    logic [31:0] load_word_d;

    load_extend u_load_extend (
        .data_i   (bus.mem_rsp_data),
        .off_i    (addr_q[1:0]),
        .funct3_i (funct3_q),
        .word_o   (load_word_d)
    );

    always_ff @(posedge WrClk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            rd_q        <= '0;
            funct3_q    <= '0;
            addr_q      <= '0;
            ready_q     <= 1'b1;
            req_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            // Commit outputs are single-cycle: cleared unless entering WB this edge.
            out_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        wen_q    <= bus.in_wen;
                        rd_q     <= bus.in_rd;
                        funct3_q <= bus.in_funct3;
                        addr_q   <= bus.in_addr;
                        ready_q  <= 1'b0;
                        if (!bus.in_is_load) begin
                            out_q   <= wb_commit(1'b0, bus.in_wen, bus.in_rd, bus.in_alu);
                            state_q <= WB;
                        end else if (load_illegal(bus.in_funct3, bus.in_addr[1:0])) begin
                            out_q   <= wb_commit(1'b1, bus.in_wen, bus.in_rd, '0);
                            state_q <= WB;
                        end else begin
                            req_valid_q <= 1'b1;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving on the last allowed cycle wins over the watchdog.
                    if (bus.mem_rsp_valid) begin
                        out_q   <= wb_commit(1'b0, wen_q, rd_q, load_word_d);
                        state_q <= WB;
                    end else if ((TIMEOUT != 0) && (cnt_q == TMO_LAST)) begin
                        out_q   <= wb_commit(1'b1, wen_q, rd_q, '0);
                        state_q <= WB;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WB: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q     <= 1'b1;
                    req_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = ready_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = {addr_q[31:2], 2'b00};
    assign bus.RegWr         = out_q.regwr;
    assign bus.Rw            = out_q.rw;
    assign bus.busW          = out_q.busw;
    assign bus.done          = out_q.done;
    assign bus.exc           = out_q.exc;

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback: ALU commits, load extraction, misaligned and
// illegal loads, request stall, reset during WAIT, and the response watchdog.
module tb_gpr_writeback;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gpr_writeback_if bus ();

    gpr_writeback #(.TIMEOUT(4)) dut (
        .WrClk (clk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic wen, input logic [4:0] rd, input logic ld,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] alu);
        @(negedge clk);
        check("ready_before_send", bus.in_ready, 1);
        bus.in_valid   = 1'b1;
        bus.in_wen     = wen;
        bus.in_rd      = rd;
        bus.in_is_load = ld;
        bus.in_funct3  = f3;
        bus.in_addr    = addr;
        bus.in_alu     = alu;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.in_is_load = 1'b0;
    endtask

    task automatic load_run(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rsp, input logic [31:0] exp_addr,
                            input logic [31:0] exp_word);
        send(1'b1, 5'd9, 1'b1, f3, addr, 32'hA5A5A5A5);
        check("req_valid", bus.mem_req_valid, 1);
        check("req_addr", bus.mem_req_addr, exp_addr);
        check("ready_in_req", bus.in_ready, 0);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("req_drop", bus.mem_req_valid, 0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = rsp;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("load_regwr", bus.RegWr, 1);
        check("load_rw", bus.Rw, 9);
        check(tag, bus.busW, exp_word);
        check("load_done", bus.done, 1);
        check("load_exc", bus.exc, 0);
    endtask

    task automatic bad_load(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        send(1'b1, 5'd9, 1'b1, f3, addr, 32'h0);
        check("bad_req_valid", bus.mem_req_valid, 0);
        check(tag, bus.exc, 1);
        check("bad_done", bus.done, 0);
        check("bad_regwr", bus.RegWr, 0);
        check("bad_busw", bus.busW, 0);
        @(negedge clk);
        check("bad_exc_pulse", bus.exc, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_wen        = 1'b0;
        bus.in_rd         = '0;
        bus.in_is_load    = 1'b0;
        bus.in_funct3     = '0;
        bus.in_addr       = '0;
        bus.in_alu        = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hDEADDEAD;

        #1;
        check("rst_ready", bus.in_ready, 1);
        check("rst_req_valid", bus.mem_req_valid, 0);
        check("rst_req_addr", bus.mem_req_addr, 0);
        check("rst_regwr", bus.RegWr, 0);
        check("rst_done", bus.done, 0);
        check("rst_exc", bus.exc, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("stale_rsp_regwr", bus.RegWr, 0);
        check("stale_rsp_done", bus.done, 0);
        check("stale_rsp_ready", bus.in_ready, 1);
        bus.mem_rsp_valid = 1'b0;

        send(1'b1, 5'd5, 1'b0, 3'b000, 32'h0, 32'h12345678);
        check("alu_regwr", bus.RegWr, 1);
        check("alu_rw", bus.Rw, 5);
        check("alu_busw", bus.busW, 32'h12345678);
        check("alu_done", bus.done, 1);
        check("alu_exc", bus.exc, 0);
        check("alu_ready_wb", bus.in_ready, 0);
        @(negedge clk);
        check("alu_idle_ready", bus.in_ready, 1);
        check("alu_pulse_done", bus.done, 0);
        check("alu_pulse_regwr", bus.RegWr, 0);

        send(1'b1, 5'd0, 1'b0, 3'b000, 32'h0, 32'hFFFFFFFF);
        check("x0_regwr", bus.RegWr, 0);
        check("x0_rw", bus.Rw, 0);
        check("x0_busw", bus.busW, 0);
        check("x0_done", bus.done, 1);

        send(1'b0, 5'd7, 1'b0, 3'b000, 32'h0, 32'h00000001);
        check("nowen_regwr", bus.RegWr, 0);
        check("nowen_busw", bus.busW, 0);
        check("nowen_done", bus.done, 1);

        load_run("lb_b3",   3'b000, 32'h80000003, 32'h80FF0000, 32'h80000000, 32'hFFFFFF80);
        load_run("lbu_b3",  3'b100, 32'h80000003, 32'h80FF0000, 32'h80000000, 32'h00000080);
        load_run("lhu_h1",  3'b101, 32'h80000002, 32'h80FF0000, 32'h80000000, 32'h000080FF);
        load_run("lh_h1",   3'b001, 32'h80000002, 32'h80FF0000, 32'h80000000, 32'hFFFF80FF);
        load_run("lh_h0",   3'b001, 32'h00000000, 32'h12348001, 32'h00000000, 32'hFFFF8001);
        load_run("lb_b1",   3'b000, 32'h00000001, 32'h12345678, 32'h00000000, 32'h00000056);
        load_run("lbu_b0",  3'b100, 32'h00000100, 32'h000000F0, 32'h00000100, 32'h000000F0);
        load_run("lw_word", 3'b010, 32'h10000004, 32'hDEADBEEF, 32'h10000004, 32'hDEADBEEF);

        bad_load("lw_misaligned_exc", 3'b010, 32'h80000002);
        bad_load("lhu_misaligned_exc", 3'b101, 32'h00000081);
        bad_load("f3_011_exc", 3'b011, 32'h00000100);
        bad_load("f3_111_exc", 3'b111, 32'h00000100);

        // Request held off for three cycles; a response during REQ must be ignored.
        send(1'b1, 5'd12, 1'b1, 3'b010, 32'h00000040, 32'h0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hBADBAD00;
        for (int i = 0; i < 3; i++) begin
            check("stall_req_valid", bus.mem_req_valid, 1);
            check("stall_req_addr", bus.mem_req_addr, 32'h00000040);
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0BADF00D;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("stall_regwr", bus.RegWr, 1);
        check("stall_rw", bus.Rw, 12);
        check("stall_busw", bus.busW, 32'h0BADF00D);

        // Response on the fourth WAIT cycle still beats the watchdog.
        send(1'b1, 5'd3, 1'b1, 3'b010, 32'h00000020, 32'h0);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("late_rsp_exc_before", bus.exc, 0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h55AA55AA;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("late_rsp_done", bus.done, 1);
        check("late_rsp_exc", bus.exc, 0);
        check("late_rsp_busw", bus.busW, 32'h55AA55AA);

        send(1'b1, 5'd3, 1'b1, 3'b010, 32'h00000024, 32'h0);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tmo_wait_exc", bus.exc, 0);
            check("tmo_wait_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        check("tmo_exc", bus.exc, 1);
        check("tmo_done", bus.done, 0);
        check("tmo_regwr", bus.RegWr, 0);
        @(negedge clk);
        check("tmo_idle_ready", bus.in_ready, 1);

        send(1'b1, 5'd4, 1'b1, 3'b010, 32'h00000030, 32'h0);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("rstwait_ready_before", bus.in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rstwait_ready_async", bus.in_ready, 1);
        check("rstwait_addr_async", bus.mem_req_addr, 0);
        check("rstwait_req_valid", bus.mem_req_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rstwait_ignored_regwr", bus.RegWr, 0);
            check("rstwait_ignored_done", bus.done, 0);
            check("rstwait_ignored_exc", bus.exc, 0);
            check("rstwait_ignored_ready", bus.in_ready, 1);
        end
        bus.mem_rsp_valid = 1'b0;

        send(1'b1, 5'd31, 1'b0, 3'b000, 32'h0, 32'hCAFEF00D);
        check("post_rst_regwr", bus.RegWr, 1);
        check("post_rst_rw", bus.Rw, 31);
        check("post_rst_busw", bus.busW, 32'hCAFEF00D);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
